sdram_line_fill: RTL and testbench
==================================

Name: sdram_line_fill

Overview:
- Cache line-fill sequencer between the SDRAM controller read-burst interface and the write port (port B) of the byte-write true-dual-port line RAM.
- Accepts a fill command and issues one SDRAM burst request.
- Writes each returned beat into the line RAM at the matching slot/word address, then reports completion or timeout.
- Port A of the line RAM stays with the CPU-side cache logic; this block never reads RAM.

Parameters:
- NUM_COL, 4, byte lanes per RAM word
- COL_WIDTH, 8, bits per lane
- DATA_WIDTH, NUM_COL*COL_WIDTH, RAM/SDRAM beat width
- ADDR_WIDTH, 8, line RAM word address width
- BEAT_BITS, 2, log2 beats per line (BURST_LEN = 2**BEAT_BITS)
- SD_AW, 24, SDRAM word address width
- TIMEOUT, 64, max idle cycles between beats in DATA (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- fill_req  in  1  fill command valid; accepted when fill_busy=0
- fill_addr  in  SD_AW  SDRAM word address of requested word
- fill_slot  in  ADDR_WIDTH-BEAT_BITS  destination line slot in RAM
- fill_busy  out  1  command in progress
- fill_done  out  1  one-cycle pulse, line written
- fill_err  out  1  one-cycle pulse, timeout abort
- sd_req  out  1  burst request, held until sd_ack
- sd_addr  out  SD_AW  burst start address
- sd_ack  in  1  controller accepted request
- sd_rvalid  in  1  read beat valid
- sd_rdata  in  DATA_WIDTH  read beat data
- ram_ena  out  1  to RAM enaB
- ram_we  out  NUM_COL  to RAM weB
- ram_addr  out  ADDR_WIDTH  to RAM addrB
- ram_din  out  DATA_WIDTH  to RAM dinB

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high (rst).
- Reset values: state IDLE; fill_busy, fill_done, fill_err, sd_req, ram_ena 0; ram_we 0; sd_addr, ram_addr, ram_din 0; beat and timeout counters 0.
- States: IDLE, REQ, DATA, DONE.
- IDLE:
  - fill_req=1 latches fill_addr and fill_slot, sets fill_busy, enters REQ.
  - The start-word offset is fill_addr[BEAT_BITS-1:0] when the feature is enabled, else 0.
- REQ:
  - sd_req=1; sd_addr = line-aligned fill_addr (low BEAT_BITS cleared) without the feature, full fill_addr with it.
  - On sd_ack, drop sd_req next cycle and enter DATA.
  - sd_rvalid in REQ is ignored.
- DATA, registered write path: each sd_rvalid cycle drives, on the next cycle:
  - ram_ena=1, ram_we all-ones;
  - ram_addr = {slot, offset+beat} with modulo-BURST_LEN wrap;
  - ram_din = sd_rdata.
  - Otherwise ram_ena=0 and ram_we=0.
  - Beat counter increments per valid beat. After beat BURST_LEN-1 is captured, enter DONE; later sd_rvalid is ignored.
- Timeout in DATA: counter resets on each sd_rvalid and increments otherwise. Reaching TIMEOUT aborts: fill_err pulses, return to IDLE, partial line left as written.
- DONE:
  - fill_done pulses the cycle the final RAM write is presented (1-cycle latency after the last beat).
  - fill_busy clears the following cycle; return to IDLE.
- fill_req while busy is ignored, not queued.
- rst mid-burst: immediate return to IDLE, no further RAM writes. In-flight SDRAM beats are the controller's responsibility.
- Latency: fill_req to sd_req = 1 cycle; sd_rvalid to RAM write = 1 cycle.

Optional Feature:
- Macro: SDRAM_LINE_FILL_CWF_EN (critical-word-first).
- Defined:
  - sd_addr carries the unaligned word address.
  - The controller returns a wrapped burst starting at that word.
  - Beat k is written to word (offset+k) mod BURST_LEN.
  - A one-cycle crit_valid pulse (extra output, present only when defined) marks the first written beat so the CPU can be released early.
- Undefined: aligned bursts, beat k to word k, no crit_valid port.

Decomposition:
- Shared package sdram_cache_pkg:
  - fill state enum (IDLE/REQ/DATA/DONE);
  - BURST_LEN derivation from BEAT_BITS;
  - line-address/slot field width helpers shared with the CPU-side cache tag logic.
- No sub-module required. The beat/timeout counter pair may be split out as sdram_fill_beat_ctr if reused by the writeback path.

Test Plan:
- Aligned fill, feature off: fill_addr=0x000104, fill_slot=3, ack after 2 cycles, beats 0xA0..0xA3 back-to-back -> sd_addr=0x000104; RAM writes addr 0x0C..0x0F with all-ones we; fill_done 1 cycle after last beat.
- Gapped beats: 3 idle cycles between each beat -> only 4 writes, correct addresses, no fill_err.
- CWF on: fill_addr=0x000106, slot=3 -> sd_addr=0x000106; writes addresses 0x0E,0x0F,0x0C,0x0D in order; crit_valid with the first write.
- Timeout: 2 beats then silence -> fill_err exactly TIMEOUT cycles after the last beat; fill_busy=0; no fill_done.
- Busy rejection and reset: fill_req pulsed during DATA is ignored. rst asserted after beat 1 -> no further ram_ena; all outputs at reset values next cycle; a new fill then completes normally.

Source files
------------

// File: rtl/sdram_cache_pkg.sv
// Shared types and field-width helpers for the SDRAM-backed line cache
// (fill sequencer and CPU-side tag logic).
package sdram_cache_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_DATA = 2'd2,
        FILL_DONE = 2'd3
    } fill_state_t;

    function automatic int burst_len(input int beat_bits);
        return 1 << beat_bits;
    endfunction

    function automatic int slot_width(input int addr_width, input int beat_bits);
        return addr_width - beat_bits;
    endfunction

    function automatic int line_addr_width(input int sd_aw, input int beat_bits);
        return sd_aw - beat_bits;
    endfunction

endpackage

// File: rtl/sdram_fill_beat_ctr.sv
// Beat counter plus inter-beat idle (timeout) counter for SDRAM burst
// sequencers; shared by the line-fill and writeback paths.
module sdram_fill_beat_ctr #(
    parameter int BEAT_BITS = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 run_i,
    input  logic                 beat_i,
    output logic [BEAT_BITS-1:0] beat_o,
    output logic                 last_o,
    output logic                 timeout_o
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [BEAT_BITS-1:0] beat_q, beat_d;
    logic [TO_W-1:0]      to_q, to_d;

    // Next-state for both counters; the idle counter restarts on every beat.
    always_comb begin
        beat_d = beat_q;
        to_d   = to_q;
        if (clr_i) begin
            beat_d = '0;
            to_d   = '0;
        end else if (run_i) begin
            if (beat_i) begin
                beat_d = beat_q + BEAT_BITS'(1);
                to_d   = '0;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end else begin
            beat_d = beat_q;
            to_d   = to_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            to_q   <= '0;
        end else begin
            beat_q <= beat_d;
            to_q   <= to_d;
        end
    end

    assign beat_o    = beat_q;
    assign last_o    = (beat_q == {BEAT_BITS{1'b1}});
    assign timeout_o = run_i && !beat_i && (to_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/sdram_line_fill.sv
// Cache line-fill sequencer: one SDRAM read burst per fill, each beat written
// to line-RAM port B. Critical-word-first is enabled by SDRAM_LINE_FILL_CWF_EN.
module sdram_line_fill
    import sdram_cache_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int BEAT_BITS  = 2,
    parameter int SD_AW      = 24,
    parameter int TIMEOUT    = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fill_req,
    input  logic [SD_AW-1:0]                  fill_addr,
    input  logic [ADDR_WIDTH-BEAT_BITS-1:0]   fill_slot,
    output logic                              fill_busy,
    output logic                              fill_done,
    output logic                              fill_err,
    output logic                              sd_req,
    output logic [SD_AW-1:0]                  sd_addr,
    input  logic                              sd_ack,
    input  logic                              sd_rvalid,
    input  logic [DATA_WIDTH-1:0]             sd_rdata,
`ifdef SDRAM_LINE_FILL_CWF_EN
    output logic                              crit_valid,
`endif
    output logic                              ram_ena,
    output logic [NUM_COL-1:0]                ram_we,
    output logic [ADDR_WIDTH-1:0]             ram_addr,
    output logic [DATA_WIDTH-1:0]             ram_din
);

    localparam int SLOT_W = slot_width(ADDR_WIDTH, BEAT_BITS);
`ifdef SDRAM_LINE_FILL_CWF_EN
    localparam bit CWF_EN = 1'b1;
`else
    localparam bit CWF_EN = 1'b0;
`endif
    // Without critical-word-first the burst always starts on the line boundary.
    localparam logic [SD_AW-1:0] ADDR_MASK = CWF_EN ? {SD_AW{1'b1}}
                                                    : ~(SD_AW'(burst_len(BEAT_BITS) - 1));

    fill_state_t               state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      sd_req_q, sd_req_d;
    logic [SD_AW-1:0]          sd_addr_q, sd_addr_d;
    logic                      ram_ena_q, ram_ena_d;
    logic [NUM_COL-1:0]        ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]     ram_din_q, ram_din_d;
    logic [SLOT_W-1:0]         slot_q, slot_d;
    logic [BEAT_BITS-1:0]      offset_q, offset_d;
    logic                      crit_q, crit_d;

    logic                      ctr_clr_s;
    logic                      ctr_run_s;
    logic                      ctr_beat_s;
    logic [BEAT_BITS-1:0]      beat_s;
    logic                      last_s;
    logic                      timeout_s;
    logic [BEAT_BITS-1:0]      word_s;

    sdram_fill_beat_ctr #(
        .BEAT_BITS (BEAT_BITS),
        .TIMEOUT   (TIMEOUT)
    ) u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ctr_clr_s),
        .run_i     (ctr_run_s),
        .beat_i    (ctr_beat_s),
        .beat_o    (beat_s),
        .last_o    (last_s),
        .timeout_o (timeout_s)
    );

    // Word within the line wraps modulo the burst length.
    assign word_s = offset_q + beat_s;

    // Fill FSM next-state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sd_req_d   = sd_req_q;
        sd_addr_d  = sd_addr_q;
        ram_ena_d  = 1'b0;
        ram_we_d   = '0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        slot_d     = slot_q;
        offset_d   = offset_q;
        crit_d     = 1'b0;
        ctr_clr_s  = 1'b0;
        ctr_run_s  = 1'b0;
        ctr_beat_s = 1'b0;
        case (state_q)
            FILL_IDLE: begin
                ctr_clr_s = 1'b1;
                if (fill_req) begin
                    slot_d    = fill_slot;
                    offset_d  = CWF_EN ? fill_addr[BEAT_BITS-1:0] : '0;
                    sd_addr_d = fill_addr & ADDR_MASK;
                    busy_d    = 1'b1;
                    sd_req_d  = 1'b1;
                    state_d   = FILL_REQ;
                end else begin
                    state_d = FILL_IDLE;
                end
            end
            FILL_REQ: begin
                ctr_clr_s = 1'b1;
                if (sd_ack) begin
                    sd_req_d = 1'b0;
                    state_d  = FILL_DATA;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            FILL_DATA: begin
                ctr_run_s  = 1'b1;
                ctr_beat_s = sd_rvalid;
                if (sd_rvalid) begin
                    ram_ena_d  = 1'b1;
                    ram_we_d   = {NUM_COL{1'b1}};
                    ram_addr_d = {slot_q, word_s};
                    ram_din_d  = sd_rdata;
                    crit_d     = (beat_s == '0);
                    if (last_s) begin
                        done_d  = 1'b1;
                        state_d = FILL_DONE;
                    end else begin
                        state_d = FILL_DATA;
                    end
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FILL_IDLE;
                end else begin
                    state_d = FILL_DATA;
                end
            end
            FILL_DONE: begin
                ctr_clr_s = 1'b1;
                busy_d    = 1'b0;
                state_d   = FILL_IDLE;
            end
            default: begin
                ctr_clr_s = 1'b1;
                busy_d    = 1'b0;
                sd_req_d  = 1'b0;
                state_d   = FILL_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sd_req_q   <= 1'b0;
            sd_addr_q  <= '0;
            ram_ena_q  <= 1'b0;
            ram_we_q   <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            slot_q     <= '0;
            offset_q   <= '0;
            crit_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sd_req_q   <= sd_req_d;
            sd_addr_q  <= sd_addr_d;
            ram_ena_q  <= ram_ena_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            slot_q     <= slot_d;
            offset_q   <= offset_d;
            crit_q     <= crit_d;
        end
    end

    assign fill_busy = busy_q;
    assign fill_done = done_q;
    assign fill_err  = err_q;
    assign sd_req    = sd_req_q;
    assign sd_addr   = sd_addr_q;
    assign ram_ena   = ram_ena_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
`ifdef SDRAM_LINE_FILL_CWF_EN
    assign crit_valid = crit_q;
`else
    logic unused_crit_s;
    assign unused_crit_s = crit_q;
`endif

endmodule

// File: tb/tb_sdram_line_fill.sv
// Directed bench for sdram_line_fill: table of fills plus timeout,
// busy-rejection and mid-burst reset sequences.
module tb_sdram_line_fill;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        fill_req;
    logic [23:0] fill_addr;
    logic [5:0]  fill_slot;
    logic        fill_busy;
    logic        fill_done;
    logic        fill_err;
    logic        sd_req;
    logic [23:0] sd_addr;
    logic        sd_ack;
    logic        sd_rvalid;
    logic [31:0] sd_rdata;
    logic        ram_ena;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
`ifdef SDRAM_LINE_FILL_CWF_EN
    logic        crit_valid;
`endif

    int checks   = 0;
    int failures = 0;

    sdram_line_fill #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .fill_req  (fill_req),
        .fill_addr (fill_addr),
        .fill_slot (fill_slot),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .fill_err  (fill_err),
        .sd_req    (sd_req),
        .sd_addr   (sd_addr),
        .sd_ack    (sd_ack),
        .sd_rvalid (sd_rvalid),
        .sd_rdata  (sd_rdata),
`ifdef SDRAM_LINE_FILL_CWF_EN
        .crit_valid(crit_valid),
`endif
        .ram_ena   (ram_ena),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic [5:0]  slot;
        int          ack_dly;
        int          gap;
        logic [31:0] dbase;
        logic [23:0] exp_sd;
        logic [31:0] exp_w;   // write addresses, beat 0 in the top byte
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic start_fill(input logic [23:0] a, input logic [5:0] s);
        fill_req  = 1'b1;
        fill_addr = a;
        fill_slot = s;
        step();
        fill_req  = 1'b0;
    endtask

    task automatic beat(input string tag, input int k, input logic [31:0] d, input logic [7:0] wa);
        sd_rvalid = 1'b1;
        sd_rdata  = d;
        step();
        sd_rvalid = 1'b0;
        chk($sformatf("%s_b%0d_ena", tag, k), 64'(ram_ena), 64'd1);
        chk($sformatf("%s_b%0d_we", tag, k), 64'(ram_we), 64'hF);
        chk($sformatf("%s_b%0d_addr", tag, k), 64'(ram_addr), 64'(wa));
        chk($sformatf("%s_b%0d_din", tag, k), 64'(ram_din), 64'(d));
`ifdef SDRAM_LINE_FILL_CWF_EN
        chk($sformatf("%s_b%0d_crit", tag, k), 64'(crit_valid), 64'(k == 0));
`endif
    endtask

    task automatic run_fill(input string tag, input vec_t v);
        start_fill(v.addr, v.slot);
        chk({tag, "_sd_req"}, 64'(sd_req), 64'd1);
        chk({tag, "_busy"}, 64'(fill_busy), 64'd1);
        chk({tag, "_sd_addr"}, 64'(sd_addr), 64'(v.exp_sd));
        for (int i = 0; i < v.ack_dly; i++) begin
            step();
            chk({tag, "_sd_req_hold"}, 64'(sd_req), 64'd1);
        end
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        chk({tag, "_sd_req_drop"}, 64'(sd_req), 64'd0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < v.gap; g++) begin
                step();
                chk($sformatf("%s_gap%0d_ena", tag, k), 64'(ram_ena), 64'd0);
                chk($sformatf("%s_gap%0d_err", tag, k), 64'(fill_err), 64'd0);
            end
            beat(tag, k, v.dbase + 32'(k), v.exp_w[31-8*k -: 8]);
            chk($sformatf("%s_b%0d_done", tag, k), 64'(fill_done), 64'(k == 3));
        end
        chk({tag, "_busy_at_done"}, 64'(fill_busy), 64'd1);
        step();
        chk({tag, "_done_pulse"}, 64'(fill_done), 64'd0);
        chk({tag, "_busy_clear"}, 64'(fill_busy), 64'd0);
        chk({tag, "_ena_after"}, 64'(ram_ena), 64'd0);
        chk({tag, "_err_none"}, 64'(fill_err), 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(fill_busy), 64'd0);
        chk({tag, "_done"}, 64'(fill_done), 64'd0);
        chk({tag, "_err"}, 64'(fill_err), 64'd0);
        chk({tag, "_sd_req"}, 64'(sd_req), 64'd0);
        chk({tag, "_sd_addr"}, 64'(sd_addr), 64'd0);
        chk({tag, "_ena"}, 64'(ram_ena), 64'd0);
        chk({tag, "_we"}, 64'(ram_we), 64'd0);
        chk({tag, "_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_din"}, 64'(ram_din), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_at;

        // addr, slot, ack delay, beat gap, data base, expected sd_addr, write addrs
`ifdef SDRAM_LINE_FILL_CWF_EN
        vecs[0] = '{24'h000104, 6'd3,  2, 0, 32'h000000A0, 24'h000104, 32'h0C0D0E0F};
        vecs[1] = '{24'h0002A7, 6'd5,  0, 3, 32'h12345670, 24'h0002A7, 32'h17141516};
        vecs[2] = '{24'hFFFFFF, 6'd63, 1, 1, 32'hDEADBEE0, 24'hFFFFFF, 32'hFFFCFDFE};
        vecs[3] = '{24'h000106, 6'd3,  0, 0, 32'h55AA0010, 24'h000106, 32'h0E0F0C0D};
`else
        vecs[0] = '{24'h000104, 6'd3,  2, 0, 32'h000000A0, 24'h000104, 32'h0C0D0E0F};
        vecs[1] = '{24'h0002A7, 6'd5,  0, 3, 32'h12345670, 24'h0002A4, 32'h14151617};
        vecs[2] = '{24'hFFFFFF, 6'd63, 1, 1, 32'hDEADBEE0, 24'hFFFFFC, 32'hFCFDFEFF};
        vecs[3] = '{24'h000106, 6'd3,  0, 0, 32'h55AA0010, 24'h000104, 32'h0C0D0E0F};
`endif

        rst = 1'b1; fill_req = 1'b0; fill_addr = '0; fill_slot = '0;
        sd_ack = 1'b0; sd_rvalid = 1'b0; sd_rdata = '0;
        step();
        step();
        chk_reset_state("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            run_fill($sformatf("fill%0d", i), vecs[i]);
            step();
        end

        // Timeout: two beats then silence.
        start_fill(24'h000200, 6'd1);
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        beat("to", 0, 32'hC0C0C0C0, 8'h04);
        beat("to", 1, 32'hC1C1C1C1, 8'h05);
        err_at = -1;
        for (int n = 1; n <= TIMEOUT + 8; n++) begin
            step();
            if (fill_done) chk("to_no_done", 64'(fill_done), 64'd0);
            if (fill_err) begin
                err_at = n;
                break;
            end
        end
        chk("to_err_latency", 64'(err_at), 64'(TIMEOUT));
        chk("to_busy_clear", 64'(fill_busy), 64'd0);
        step();
        chk("to_err_pulse", 64'(fill_err), 64'd0);
        chk("to_idle_no_req", 64'(sd_req), 64'd0);

        // Busy rejection, then reset mid-burst.
        start_fill(24'h000300, 6'd2);
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        beat("rs", 0, 32'h01010101, 8'h08);
        fill_req  = 1'b1;
        fill_addr = 24'h000ABC;
        fill_slot = 6'd9;
        step();
        fill_req  = 1'b0;
        chk("rej_sd_req", 64'(sd_req), 64'd0);
        chk("rej_sd_addr", 64'(sd_addr), 64'h000300);
        chk("rej_busy", 64'(fill_busy), 64'd1);
        beat("rs", 1, 32'h02020202, 8'h09);
        rst       = 1'b1;
        sd_rvalid = 1'b1;
        sd_rdata  = 32'h03030303;
        step();
        chk_reset_state("midrst");
        rst = 1'b0;
        step();
        sd_rvalid = 1'b0;
        chk("midrst_no_write", 64'(ram_ena), 64'd0);
        chk("midrst_not_queued", 64'(sd_req), 64'd0);
        run_fill("after_rst", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
